reg_block_mp: RTL
=================

// Module: reg_block_mp
// PURPOSE
// Parametrised multi-read-port register file for address-windowed register space.
// Writes land in a 2^ACTUAL_ADDR_WIDTH entry array only when the upper address bits match BASE_ADDR.
// Has NUM_RD_PORTS registered read ports with write-to-read bypass and a per-port out-of-window miss flag.
// Clears all entries with a hardware sweep after reset and on request, reporting busy while clearing.
// PARAMETERS
// IN_ADDR_WIDTH      7   write address width
// OUT_ADDR_WIDTH     9   read address width (per port)
// ACTUAL_ADDR_WIDTH  5   index bits; REG_DEPTH = 1<<ACTUAL_ADDR_WIDTH
// DATA_WIDTH         16  entry width
// NUM_RD_PORTS       2   independent read ports (>=1)
// BASE_ADDR          0   required value of address bits above ACTUAL_ADDR_WIDTH (truncated per port width)
// PORTS
// clk         in   1                          rising-edge clock
// rst_n       in   1                          asynchronous active-low reset
// wr_en       in   1                          write request
// Addr_In     in   IN_ADDR_WIDTH              write address
// Data_In     in   DATA_WIDTH                 write data
// clear_req   in   1                          single-cycle pulse: start clear sweep
// busy        out  1                          clear sweep in progress
// rd_en       in   NUM_RD_PORTS               per-port read request
// Addr_Out    in   NUM_RD_PORTS*OUT_ADDR_WIDTH  read addresses, port i at [i*OUT_ADDR_WIDTH +: OUT_ADDR_WIDTH]
// Data_Out    out  NUM_RD_PORTS*DATA_WIDTH      registered read data, same packing
// rd_valid    out  NUM_RD_PORTS               read data valid, 1 cycle after rd_en
// rd_miss     out  NUM_RD_PORTS               read address was outside the window
// BEHAVIOUR
// - Window hit: addr[W-1:ACTUAL_ADDR_WIDTH] == BASE_ADDR; index = addr[ACTUAL_ADDR_WIDTH-1:0].
// - rst_n low (async): state=CLEAR, sweep counter=0, busy=1, Data_Out=0, rd_valid=0, rd_miss=0.
//   Array contents are not reset directly; the sweep zeroes them.
// - FSM IDLE/CLEAR. In CLEAR, each clk writes 0 to entry[ctr] and increments ctr.
//   After writing entry REG_DEPTH-1, the FSM goes to IDLE and busy falls on that edge.
//   busy is high for exactly REG_DEPTH cycles after reset release or after the clear_req edge.
// - IDLE + clear_req: next state CLEAR, ctr=0. clear_req in CLEAR is ignored (no restart).
// - Write accepted iff state==IDLE && !clear_req && wr_en && window hit; entry updated at the clk edge.
//   All other writes are silently dropped.
// - Read, per port, at an edge with rd_en[i]=1: rd_valid[i]=1 in the next cycle, otherwise 0.
//   Hit, IDLE: Data_Out = entry[index]; a write accepted at the same edge to the same index returns the new Data_In (bypass).
//   Miss: Data_Out=0, rd_miss=1.
//   Hit while busy (CLEAR): Data_Out=0, rd_miss=0.
//   rd_en=0: Data_Out holds its previous value, rd_miss=0.
// - Ports are independent; any number of ports may read the same index in the same cycle.
// - Read latency is 1 cycle and fixed; there is no backpressure.
// - Reset asserted mid-sweep restarts the sweep from 0 after release.
// TESTING
// 1. Release rst_n, count busy -> high for exactly 32 cycles; all 32 entries read back 0x0000 with rd_miss=0.
// 2. Write 0xBEEF to Addr_In=0x05, then read Addr_Out=0x005 on port 0 -> next cycle Data_Out[15:0]=0xBEEF, rd_valid[0]=1.
// 3. Write Addr_In=0x25 (out of window) with 0x1234, then read 0x005 -> still 0xBEEF; read 0x105 -> Data_Out=0, rd_miss=1.
// 4. Write 0xA5A5 to 0x0A while ports 0 and 1 both read 0x00A at the same edge -> both return 0xA5A5 (bypass).
// 5. clear_req pulse with a same-cycle write, plus a second clear_req 10 cycles later -> write dropped, busy high 32 cycles, all entries 0.
// 6. Drop rst_n at sweep count 16, release it -> busy high a fresh 32 cycles, outputs held at 0 during reset.

Source files
------------

// File: rtl/reg_block_mp.sv
// Windowed register file with NUM_RD_PORTS registered read ports, write-to-read bypass,
// out-of-window miss flags and a hardware clear sweep after reset or on request.
module reg_block_mp #(
  parameter int          IN_ADDR_WIDTH     = 7,
  parameter int          OUT_ADDR_WIDTH    = 9,
  parameter int          ACTUAL_ADDR_WIDTH = 5,
  parameter int          DATA_WIDTH        = 16,
  parameter int          NUM_RD_PORTS      = 2,
  parameter int unsigned BASE_ADDR         = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic [IN_ADDR_WIDTH-1:0]               Addr_In,
  input  logic [DATA_WIDTH-1:0]                  Data_In,
  input  logic                                   clear_req,
  output logic                                   busy,
  input  logic [NUM_RD_PORTS-1:0]                rd_en,
  input  logic [NUM_RD_PORTS*OUT_ADDR_WIDTH-1:0] Addr_Out,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]     Data_Out,
  output logic [NUM_RD_PORTS-1:0]                rd_valid,
  output logic [NUM_RD_PORTS-1:0]                rd_miss
);

  localparam int REG_DEPTH = 1 << ACTUAL_ADDR_WIDTH;
  localparam int WR_TAG_W  = IN_ADDR_WIDTH - ACTUAL_ADDR_WIDTH;
  localparam int RD_TAG_W  = OUT_ADDR_WIDTH - ACTUAL_ADDR_WIDTH;
  localparam logic [WR_TAG_W-1:0]          WR_BASE  = WR_TAG_W'(BASE_ADDR);
  localparam logic [RD_TAG_W-1:0]          RD_BASE  = RD_TAG_W'(BASE_ADDR);
  localparam logic [ACTUAL_ADDR_WIDTH-1:0] LAST_IDX = ACTUAL_ADDR_WIDTH'(REG_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                         state_r, state_s;
  logic [ACTUAL_ADDR_WIDTH-1:0]   ctr_r, ctr_s;
  logic [DATA_WIDTH-1:0]          mem_r [REG_DEPTH];

  logic                           wr_hit_s;
  logic [ACTUAL_ADDR_WIDTH-1:0]   wr_idx_s;
  logic                           wr_accept_s;
  logic [NUM_RD_PORTS-1:0]        rd_hit_s;
  logic [DATA_WIDTH-1:0]          rd_data_s [NUM_RD_PORTS];

  // Sweep FSM state and counter; reset lands in CLEAR so the array is zeroed after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      ctr_r   <= '0;
    end else begin
      state_r <= state_s;
      ctr_r   <= ctr_s;
    end
  end

  always_comb begin
    state_s = state_r;
    ctr_s   = ctr_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_req) begin
          state_s = ST_CLEAR;
          ctr_s   = '0;
        end else begin
          state_s = ST_IDLE;
          ctr_s   = ctr_r;
        end
      end
      ST_CLEAR: begin
        ctr_s = ctr_r + ACTUAL_ADDR_WIDTH'(1);
        if (ctr_r == LAST_IDX) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      default: begin
        state_s = ST_CLEAR;
        ctr_s   = '0;
      end
    endcase
  end

  assign busy = (state_r == ST_CLEAR);

  assign wr_hit_s    = (Addr_In[IN_ADDR_WIDTH-1:ACTUAL_ADDR_WIDTH] == WR_BASE);
  assign wr_idx_s    = Addr_In[ACTUAL_ADDR_WIDTH-1:0];
  assign wr_accept_s = (state_r == ST_IDLE) && !clear_req && wr_en && wr_hit_s;

  // Array storage is not reset; the sweep owns it while clearing.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[ctr_r] <= '0;
    end else if (wr_accept_s) begin
      mem_r[wr_idx_s] <= Data_In;
    end
  end

  // Per-port lookup: miss or busy reads return zero, a same-edge accepted write is bypassed.
  always_comb begin
    rd_hit_s = '0;
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      rd_data_s[i] = '0;
      rd_hit_s[i]  = (Addr_Out[i*OUT_ADDR_WIDTH+ACTUAL_ADDR_WIDTH +: RD_TAG_W] == RD_BASE);
      if (!rd_hit_s[i] || (state_r == ST_CLEAR)) begin
        rd_data_s[i] = '0;
      end else if (wr_accept_s &&
                   (wr_idx_s == Addr_Out[i*OUT_ADDR_WIDTH +: ACTUAL_ADDR_WIDTH])) begin
        rd_data_s[i] = Data_In;
      end else begin
        rd_data_s[i] = mem_r[Addr_Out[i*OUT_ADDR_WIDTH +: ACTUAL_ADDR_WIDTH]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Data_Out <= '0;
      rd_valid <= '0;
      rd_miss  <= '0;
    end else begin
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
        rd_valid[i] <= rd_en[i];
        if (rd_en[i]) begin
          Data_Out[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data_s[i];
          rd_miss[i]                           <= !rd_hit_s[i];
        end else begin
          rd_miss[i] <= 1'b0;
        end
      end
    end
  end

endmodule
